// File: rtl/serial_word_shifter_pkg.sv
// Shared types for the serial word path.
// Also imported by the downstream parity FSM stage.
package serial_word_shifter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  // Counter width for a count range of n values, never below 1.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_word_shifter_if.sv
// Parallel word handshake into the serial shifter.
// master drives the word, slave accepts it.
interface serial_word_shifter_if #(
  parameter int WIDTH = 8
) ();

  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;

  modport master (
    output din,
    output din_valid,
    input  din_ready
  );

  modport slave (
    input  din,
    input  din_valid,
    output din_ready
  );

endinterface

// File: rtl/serial_word_shifter.sv
// Parallel-to-serial shifter: one bit per clk on w,
// with sof/eof frame markers and optional idle gap.
module serial_word_shifter
  import serial_word_shifter_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int LSB_FIRST  = 1,
  parameter int GAP_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  serial_word_shifter_if.slave  in_if,
  output logic                  w,
  output logic                  w_valid,
  output logic                  sof,
  output logic                  eof,
  output logic                  busy
);

  localparam int CW = cnt_w(WIDTH);
  localparam int GW = cnt_w(GAP_CYCLES + 1);

  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [GW-1:0] LAST_GAP =
    (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [GW-1:0]    gcnt_q, gcnt_d;
  logic             w_q, w_d;
  logic             wv_q, wv_d;
  logic             sof_q, sof_d;
  logic             eof_q, eof_d;

  logic             ready;
  logic             take;
  logic [CW-1:0]    cnt_inc;
  logic             ld_bit;
  logic [WIDTH-1:0] ld_rest;
  logic             nx_bit;
  logic [WIDTH-1:0] nx_rest;

  assign cnt_inc = cnt_q + 1'b1;

  // First bit of a new word and what remains to shift.
  always_comb begin
    ld_bit  = 1'b0;
    ld_rest = '0;
    nx_bit  = 1'b0;
    nx_rest = '0;
    if (LSB_FIRST != 0) begin
      ld_bit  = in_if.din[0];
      ld_rest = in_if.din >> 1;
      nx_bit  = sreg_q[0];
      nx_rest = sreg_q >> 1;
    end else begin
      ld_bit  = in_if.din[WIDTH-1];
      ld_rest = in_if.din << 1;
      nx_bit  = sreg_q[WIDTH-1];
      nx_rest = sreg_q << 1;
    end
  end

  always_comb begin
    ready = 1'b0;
    unique case (state_q)
      ST_IDLE:  ready = 1'b1;
      ST_SHIFT: ready = (GAP_CYCLES == 0) &&
                        (cnt_q == LAST_BIT);
      ST_GAP:   ready = (gcnt_q == LAST_GAP);
      default:  ready = 1'b0;
    endcase
  end

  assign take = ready & in_if.din_valid;

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    gcnt_d  = gcnt_q;
    w_d     = 1'b0;
    wv_d    = 1'b0;
    sof_d   = 1'b0;
    eof_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (take) begin
          state_d = ST_SHIFT;
          sreg_d  = ld_rest;
          cnt_d   = '0;
          w_d     = ld_bit;
          wv_d    = 1'b1;
          sof_d   = 1'b1;
          eof_d   = (WIDTH == 1);
        end
      end
      ST_SHIFT: begin
        if (cnt_q != LAST_BIT) begin
          sreg_d = nx_rest;
          cnt_d  = cnt_inc;
          w_d    = nx_bit;
          wv_d   = 1'b1;
          eof_d  = (cnt_inc == LAST_BIT);
        end else if (GAP_CYCLES > 0) begin
          state_d = ST_GAP;
          gcnt_d  = '0;
        end else if (take) begin
          sreg_d = ld_rest;
          cnt_d  = '0;
          w_d    = ld_bit;
          wv_d   = 1'b1;
          sof_d  = 1'b1;
          eof_d  = (WIDTH == 1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gcnt_q != LAST_GAP) begin
          gcnt_d = gcnt_q + 1'b1;
        end else if (take) begin
          state_d = ST_SHIFT;
          sreg_d  = ld_rest;
          cnt_d   = '0;
          w_d     = ld_bit;
          wv_d    = 1'b1;
          sof_d   = 1'b1;
          eof_d   = (WIDTH == 1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      gcnt_q  <= '0;
      w_q     <= 1'b0;
      wv_q    <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      gcnt_q  <= gcnt_d;
      w_q     <= w_d;
      wv_q    <= wv_d;
      sof_q   <= sof_d;
      eof_q   <= eof_d;
    end
  end

  assign in_if.din_ready = ready;
  assign w       = w_q;
  assign w_valid = wv_q;
  assign sof     = sof_q;
  assign eof     = eof_q;
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_serial_word_shifter.sv
// Directed bench for serial_word_shifter across
// four parameter sets sharing one clock and reset.
module tb_serial_word_shifter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  serial_word_shifter_if #(.WIDTH(8)) i8 ();
  serial_word_shifter_if #(.WIDTH(8)) im ();
  serial_word_shifter_if #(.WIDTH(8)) ig ();
  serial_word_shifter_if #(.WIDTH(1)) i1 ();

  logic w8, wv8, sf8, ef8, bz8;
  logic wm, wvm, sfm, efm, bzm;
  logic wg, wvg, sfg, efg, bzg;
  logic w1, wv1, sf1, ef1, bz1;

  serial_word_shifter #(
    .WIDTH(8), .LSB_FIRST(1), .GAP_CYCLES(0)
  ) u8 (
    .clk(clk), .reset(reset), .in_if(i8.slave),
    .w(w8), .w_valid(wv8), .sof(sf8),
    .eof(ef8), .busy(bz8)
  );

  serial_word_shifter #(
    .WIDTH(8), .LSB_FIRST(0), .GAP_CYCLES(0)
  ) um (
    .clk(clk), .reset(reset), .in_if(im.slave),
    .w(wm), .w_valid(wvm), .sof(sfm),
    .eof(efm), .busy(bzm)
  );

  serial_word_shifter #(
    .WIDTH(8), .LSB_FIRST(1), .GAP_CYCLES(2)
  ) ug (
    .clk(clk), .reset(reset), .in_if(ig.slave),
    .w(wg), .w_valid(wvg), .sof(sfg),
    .eof(efg), .busy(bzg)
  );

  serial_word_shifter #(
    .WIDTH(1), .LSB_FIRST(1), .GAP_CYCLES(0)
  ) u1 (
    .clk(clk), .reset(reset), .in_if(i1.slave),
    .w(w1), .w_valid(wv1), .sof(sf1),
    .eof(ef1), .busy(bz1)
  );

  // Observed bundle: {w, w_valid, sof, eof, busy, din_ready}
  logic [5:0] o8, om, og, o1;
  assign o8 = {w8, wv8, sf8, ef8, bz8, i8.din_ready};
  assign om = {wm, wvm, sfm, efm, bzm, im.din_ready};
  assign og = {wg, wvg, sfg, efg, bzg, ig.din_ready};
  assign o1 = {w1, wv1, sf1, ef1, bz1, i1.din_ready};

  typedef struct {
    int         dut;
    logic [7:0] din;
    logic       dv;
    logic [5:0] exp;
    string      name;
  } vec_t;

  vec_t q[$];
  int   nchk = 0;
  int   nerr = 0;

  localparam logic [5:0] IDL = 6'b000001;
  localparam logic [5:0] MID = 6'b010010;

  task automatic check(input string nm,
                       input logic [5:0] got,
                       input logic [5:0] want);
    nchk++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got %b want %b", nm, got, want);
    end
  endtask

  task automatic push(input int d, input logic [7:0] din,
                      input logic dv, input logic [5:0] e,
                      input string nm);
    vec_t v;
    v.dut  = d;
    v.din  = din;
    v.dv   = dv;
    v.exp  = e;
    v.name = nm;
    q.push_back(v);
  endtask

  function automatic logic [5:0] obs(input int d);
    case (d)
      0:       return o8;
      1:       return om;
      2:       return og;
      default: return o1;
    endcase
  endfunction

  task automatic drive(input int d, input logic [7:0] din,
                       input logic dv);
    case (d)
      0: begin i8.din = din; i8.din_valid = dv; end
      1: begin im.din = din; im.din_valid = dv; end
      2: begin ig.din = din; ig.din_valid = dv; end
      default: begin
        i1.din = din[0:0];
        i1.din_valid = dv;
      end
    endcase
  endtask

  // Each row: check this cycle's outputs, then drive this cycle's inputs.
  task automatic run_table();
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      check($sformatf("%s[%0d]", q[i].name, i),
            obs(q[i].dut), q[i].exp);
      drive(q[i].dut, q[i].din, q[i].dv);
    end
    q.delete();
  endtask

  initial begin
    reset = 1'b0;
    for (int d = 0; d < 4; d++) drive(d, 8'h00, 1'b0);

    // Reset held with a pending word: nothing may start
    drive(0, 8'hA5, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_hold", {1'b0, o8[5:1]}, 6'b0);
      check("rst_hold_busy", {5'b0, bz8}, 6'b0);
    end
    drive(0, 8'h00, 1'b0);
    #2 reset = 1'b1;
    #1 check("rst_release", o8, IDL);
    @(negedge clk);
    check("rst_idle", o8, IDL);

    // 8'hA5, LSB first; din change while busy is ignored
    push(0, 8'hA5, 1, IDL,       "a5");
    push(0, 8'hFF, 0, 6'b111010, "a5");
    push(0, 8'h00, 0, MID,       "a5");
    push(0, 8'h00, 0, 6'b110010, "a5");
    push(0, 8'h00, 0, MID,       "a5");
    push(0, 8'h00, 0, MID,       "a5");
    push(0, 8'h00, 0, 6'b110010, "a5");
    push(0, 8'h00, 0, MID,       "a5");
    push(0, 8'h00, 0, 6'b110111, "a5");
    push(0, 8'h00, 0, IDL,       "a5");
    push(0, 8'h00, 0, IDL,       "a5");

    // MSB first, back-to-back 8'h81 then 8'h3C
    push(1, 8'h81, 1, IDL,       "msb");
    push(1, 8'h3C, 1, 6'b111010, "msb");
    for (int i = 0; i < 6; i++)
      push(1, 8'h3C, 1, MID,     "msb");
    push(1, 8'h3C, 1, 6'b110111, "msb");
    push(1, 8'h00, 0, 6'b011010, "msb");
    push(1, 8'h00, 0, MID,       "msb");
    for (int i = 0; i < 4; i++)
      push(1, 8'h00, 0, 6'b110010, "msb");
    push(1, 8'h00, 0, MID,       "msb");
    push(1, 8'h00, 0, 6'b010111, "msb");
    push(1, 8'h00, 0, IDL,       "msb");

    // Two-cycle gap between 8'hFF and 8'h00
    push(2, 8'hFF, 1, IDL,       "gap");
    push(2, 8'h00, 1, 6'b111010, "gap");
    for (int i = 0; i < 6; i++)
      push(2, 8'h00, 1, 6'b110010, "gap");
    push(2, 8'h00, 1, 6'b110110, "gap");
    push(2, 8'h00, 1, 6'b000010, "gap");
    push(2, 8'h00, 1, 6'b000011, "gap");
    push(2, 8'h00, 0, 6'b011010, "gap");
    for (int i = 0; i < 6; i++)
      push(2, 8'h00, 0, MID,     "gap");
    push(2, 8'h00, 0, 6'b010110, "gap");
    push(2, 8'h00, 0, 6'b000010, "gap");
    push(2, 8'h00, 0, 6'b000011, "gap");
    push(2, 8'h00, 0, IDL,       "gap");

    // WIDTH=1 stream 1,0,1
    push(3, 8'h01, 1, IDL,       "w1");
    push(3, 8'h00, 1, 6'b111111, "w1");
    push(3, 8'h01, 1, 6'b011111, "w1");
    push(3, 8'h00, 0, 6'b111111, "w1");
    push(3, 8'h00, 0, IDL,       "w1");
    run_table();

    // 8'hF0 interrupted by reset at bit 4
    push(0, 8'hF0, 1, IDL,       "f0");
    push(0, 8'h00, 0, 6'b011010, "f0");
    push(0, 8'h00, 0, MID,       "f0");
    push(0, 8'h00, 0, MID,       "f0");
    push(0, 8'h00, 0, MID,       "f0");
    push(0, 8'h00, 0, 6'b110010, "f0");
    run_table();
    #2 reset = 1'b0;
    #1 check("rst_mid", {1'b0, o8[5:1]}, 6'b0);
    repeat (2) @(negedge clk);
    check("rst_mid_hold", {1'b0, o8[5:1]}, 6'b0);
    #2 reset = 1'b1;

    // Clean 8'h0F after release, no leftover of 8'hF0
    push(0, 8'h00, 0, IDL,       "0f");
    push(0, 8'h0F, 1, IDL,       "0f");
    push(0, 8'h00, 0, 6'b111010, "0f");
    push(0, 8'h00, 0, 6'b110010, "0f");
    push(0, 8'h00, 0, 6'b110010, "0f");
    push(0, 8'h00, 0, 6'b110010, "0f");
    push(0, 8'h00, 0, MID,       "0f");
    push(0, 8'h00, 0, MID,       "0f");
    push(0, 8'h00, 0, MID,       "0f");
    push(0, 8'h00, 0, 6'b010111, "0f");
    push(0, 8'h00, 0, IDL,       "0f");
    run_table();

    $display("Result: errors=%0d of %0d checks",
             nerr, nchk);
    $finish;
  end

endmodule
